// File: rtl/asp_irq_responder_if.sv
// Bus bundle for asp_irq_responder: the 64-bit AVMM CSR port and the
// req/ack interrupt message port toward the host interrupt interface.
interface asp_irq_responder_if #(
    parameter int unsigned CSR_ADDR_WIDTH = 3
);
    logic [CSR_ADDR_WIDTH-1:0] avmm_address;
    logic                      avmm_read;
    logic                      avmm_write;
    logic [63:0]               avmm_writedata;
    logic [7:0]                avmm_byteenable;
    logic [63:0]               avmm_readdata;
    logic                      avmm_readdatavalid;
    logic                      avmm_waitrequest;
    logic                      irq_req;
    logic [1:0]                irq_vec;
    logic                      irq_ack;

    // Responder side (the design).
    modport slave (
        input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
        input  irq_ack,
        output avmm_readdata, avmm_readdatavalid, avmm_waitrequest,
        output irq_req, irq_vec
    );

    // Host / CSR initiator side.
    modport master (
        output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
        output irq_ack,
        input  avmm_readdata, avmm_readdatavalid, avmm_waitrequest,
        input  irq_req, irq_vec
    );
endinterface

// File: rtl/asp_irq_responder.sv
// ASP interrupt responder: edge-detects the DMA_0 / kernel / DMA_1 lines into a
// pending register, masks them, and sends one req/ack message per event.
// CSRs (64-bit words): 0 PENDING, 1 MASK, 2 CLEAR (W1C), 3 RAW, 4 COUNT/busy.
// Optional feature: define ASP_IRQ_HOLDOFF_EN to enforce an idle gap of
// HOLDOFF_CYCLES after each ack before the next message may start.
module asp_irq_responder #(
    parameter int unsigned NUM_IRQ_LINES  = 4,
    parameter int unsigned NUM_IRQ_USED   = 3,
    parameter int unsigned CSR_ADDR_WIDTH = 3,
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IRQ_LINES-1:0] irq_in,
    asp_irq_responder_if.slave       bus_io
);
    localparam logic [NUM_IRQ_LINES-1:0] UsedMask =
        NUM_IRQ_LINES'((64'd1 << NUM_IRQ_USED) - 64'd1);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrPending = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMask    = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrClear   = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrRaw     = CSR_ADDR_WIDTH'(3);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrCount   = CSR_ADDR_WIDTH'(4);

`ifdef ASP_IRQ_HOLDOFF_EN
    localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;
    logic [HoldW-1:0] hold_cnt_q;
`else
    localparam int unsigned unused_holdoff = HOLDOFF_CYCLES;
    typedef enum logic [0:0] {StIdle, StReq} state_e;
`endif

    state_e                   state_q;
    logic [NUM_IRQ_LINES-1:0] irq_in_q, pending_q, sent_q, mask_q;
    logic [NUM_IRQ_LINES-1:0] pending_d, sent_d, mask_d;
    logic [NUM_IRQ_LINES-1:0] rise, clr, eligible, ack_set;
    logic [63:0]              wmask, wdata, rdata_d, rdata_q;
    logic                     rvalid_q;
    logic [31:0]              msg_count_q;
    logic                     irq_req_q;
    logic [1:0]               irq_vec_q, first_idx;
    logic                     wr_mask, wr_clear, ack_fire, busy;
    logic                     unused_wdata;

    assign wr_mask      = bus_io.avmm_write && (bus_io.avmm_address == AddrMask);
    assign wr_clear     = bus_io.avmm_write && (bus_io.avmm_address == AddrClear);
    assign wdata        = bus_io.avmm_writedata & wmask;
    assign unused_wdata = ^wdata[63:NUM_IRQ_LINES];

    assign rise     = irq_in & ~irq_in_q & UsedMask;
    assign clr      = wr_clear ? wdata[NUM_IRQ_LINES-1:0] : '0;
    assign eligible = pending_q & ~mask_q & ~sent_q;
    assign ack_fire = (state_q == StReq) && bus_io.irq_ack;
    assign busy     = (state_q != StIdle);

    // Expand byte enables into a per-bit write mask.
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            wmask[b*8 +: 8] = {8{bus_io.avmm_byteenable[b]}};
        end
    end

    // Next-state for pending/sent/mask; a rise or ack beats a same-cycle clear.
    always_comb begin
        ack_set = '0;
        if (ack_fire) ack_set[irq_vec_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
        sent_d    = (sent_q & ~clr) | ack_set;
        mask_d    = mask_q;
        if (wr_mask) mask_d = (mask_q & ~wmask[NUM_IRQ_LINES-1:0]) | wdata[NUM_IRQ_LINES-1:0];
    end

    // Lowest-index eligible line wins.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_IRQ_USED - 1; i >= 0; i--) begin
            if (eligible[i]) first_idx = 2'(i);
        end
    end

    // CSR read mux; values are taken before any same-cycle write lands.
    always_comb begin
        rdata_d = '0;
        if (bus_io.avmm_read) begin
            case (bus_io.avmm_address)
                AddrPending: rdata_d[NUM_IRQ_LINES-1:0] = pending_q;
                AddrMask:    rdata_d[NUM_IRQ_LINES-1:0] = mask_q;
                AddrRaw:     rdata_d[NUM_IRQ_LINES-1:0] = irq_in_q;
                AddrCount:   rdata_d = {busy, 31'd0, msg_count_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    // Line sampling, event bookkeeping and CSR state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_in_q  <= '0;
            pending_q <= '0;
            sent_q    <= '0;
            mask_q    <= '1;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            irq_in_q  <= irq_in;
            pending_q <= pending_d;
            sent_q    <= sent_d;
            mask_q    <= mask_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= bus_io.avmm_read;
        end
    end

    // Message FSM with registered req/vec; the request is never withdrawn once raised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            irq_req_q   <= 1'b0;
            irq_vec_q   <= '0;
            msg_count_q <= '0;
`ifdef ASP_IRQ_HOLDOFF_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (eligible != '0) begin
                        irq_vec_q <= first_idx;
                        irq_req_q <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (bus_io.irq_ack) begin
                        irq_req_q <= 1'b0;
                        if (msg_count_q != '1) msg_count_q <= msg_count_q + 32'd1;
`ifdef ASP_IRQ_HOLDOFF_EN
                        hold_cnt_q <= HoldW'(HOLDOFF_CYCLES - 1);
                        state_q    <= StHold;
`else
                        state_q    <= StIdle;
`endif
                    end
                end
`ifdef ASP_IRQ_HOLDOFF_EN
                StHold: begin
                    if (hold_cnt_q == '0) state_q <= StIdle;
                    else hold_cnt_q <= hold_cnt_q - 1'b1;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.avmm_readdata      = rdata_q;
    assign bus_io.avmm_readdatavalid = rvalid_q;
    assign bus_io.avmm_waitrequest   = 1'b0;
    assign bus_io.irq_req            = irq_req_q;
    assign bus_io.irq_vec            = irq_vec_q;
endmodule

// File: tb/tb_asp_irq_responder.sv
// Self-checking bench for asp_irq_responder: directed scenarios plus a
// randomized phase checked against a set-based model of pending/mask/order.
module tb_asp_irq_responder;
    localparam int unsigned NumLines = 4;
    localparam int unsigned NumUsed  = 3;
    localparam int unsigned AddrW    = 3;
    localparam int unsigned Holdoff  = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NumLines-1:0] irq_in = '0;
    int                  total = 0;
    int                  bad = 0;

    asp_irq_responder_if #(.CSR_ADDR_WIDTH(AddrW)) bus ();

    asp_irq_responder #(
        .NUM_IRQ_LINES (NumLines),
        .NUM_IRQ_USED  (NumUsed),
        .CSR_ADDR_WIDTH(AddrW),
        .HOLDOFF_CYCLES(Holdoff)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .irq_in (irq_in),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.avmm_address    = '0;
        bus.avmm_read       = 1'b0;
        bus.avmm_write      = 1'b0;
        bus.avmm_writedata  = '0;
        bus.avmm_byteenable = '0;
        bus.irq_ack         = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        irq_in  = '0;
        #3;
        reset_n = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic csr_write(input logic [AddrW-1:0] a, input logic [63:0] d,
                             input logic [7:0] be);
        bus.avmm_address    = a;
        bus.avmm_writedata  = d;
        bus.avmm_byteenable = be;
        bus.avmm_write      = 1'b1;
        tick();
        bus.avmm_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [AddrW-1:0] a, output logic [63:0] d);
        bus.avmm_address = a;
        bus.avmm_read    = 1'b1;
        tick();
        bus.avmm_read    = 1'b0;
        d = bus.avmm_readdata;
    endtask

    task automatic pulse(input logic [NumLines-1:0] p);
        irq_in = p;
        tick();
        irq_in = '0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (bus.irq_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i < budget) tick();
        end
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        bus_idle();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.irq_req, bus.irq_vec, bus.avmm_readdatavalid, bus.avmm_waitrequest} !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {bus.irq_req, bus.irq_vec, bus.avmm_readdatavalid, bus.avmm_waitrequest});
        end
        total++;
        if (bus.avmm_readdata !== 64'd0) begin
            bad++;
            $display("FAIL reset_readdata: got %h want 0", bus.avmm_readdata);
        end
        tick();
        reset_n = 1'b1;
        tick();
        csr_read(3'd1, d);
        total++;
        if (d !== 64'hF) begin bad++; $display("FAIL reset_mask: got %h want f", d); end
        csr_read(3'd0, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL reset_pending: got %h want 0", d); end
        csr_read(3'd4, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL reset_count: got %h want 0", d); end
    endtask

    task automatic test_single();
        logic [63:0] d;
        bit ok;
        int seen;
        do_reset();
        csr_write(3'd1, 64'd0, 8'hFF);
        pulse(4'b0010);
        wait_req(6, ok);
        total++;
        if (!ok || bus.irq_vec !== 2'd1) begin
            bad++;
            $display("FAIL single_req: req=%b vec=%0d want req=1 vec=1", ok, bus.irq_vec);
        end
        csr_read(3'd0, d);
        total++;
        if (d !== 64'h2) begin bad++; $display("FAIL single_pending: got %h want 2", d); end
        csr_read(3'd4, d);
        total++;
        if (d !== {1'b1, 63'd0}) begin
            bad++;
            $display("FAIL single_busy: got %h want 8000000000000000", d);
        end
        do_ack();
        total++;
        if (bus.irq_req !== 1'b0) begin
            bad++;
            $display("FAIL single_req_drop: got %b want 0", bus.irq_req);
        end
        csr_read(3'd4, d);
        total++;
        if (d !== 64'd1) begin bad++; $display("FAIL single_count: got %h want 1", d); end
        // Held-high line: exactly one message for one rising edge.
        csr_write(3'd2, 64'h2, 8'hFF);
        irq_in = 4'b0010;
        wait_req(6, ok);
        total++;
        if (!ok || bus.irq_vec !== 2'd1) begin
            bad++;
            $display("FAIL held_req: req=%b vec=%0d want req=1 vec=1", ok, bus.irq_vec);
        end
        do_ack();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.irq_req === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL held_no_repeat: got %0d req cycles want 0", seen); end
        irq_in = '0;
        csr_read(3'd4, d);
        total++;
        if (d !== 64'd2) begin bad++; $display("FAIL held_count: got %h want 2", d); end
    endtask

    task automatic test_two_lines();
        logic [63:0] d;
        bit ok;
        do_reset();
        csr_write(3'd1, 64'd0, 8'hFF);
        pulse(4'b0101);
        wait_req(6, ok);
        total++;
        if (!ok || bus.irq_vec !== 2'd0) begin
            bad++;
            $display("FAIL two_first: req=%b vec=%0d want req=1 vec=0", ok, bus.irq_vec);
        end
        do_ack();
        wait_req(6, ok);
        total++;
        if (!ok || bus.irq_vec !== 2'd2) begin
            bad++;
            $display("FAIL two_second: req=%b vec=%0d want req=1 vec=2", ok, bus.irq_vec);
        end
        do_ack();
        csr_read(3'd4, d);
        total++;
        if (d !== 64'd2) begin bad++; $display("FAIL two_count: got %h want 2", d); end
        csr_read(3'd0, d);
        total++;
        if (d !== 64'h5) begin bad++; $display("FAIL two_pending: got %h want 5", d); end
    endtask

    task automatic test_mask_then_clear_race();
        logic [63:0] d;
        int seen;
        do_reset();
        csr_write(3'd1, 64'h1, 8'hFF);
        pulse(4'b0001);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.irq_req === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL masked_quiet: got %0d req cycles want 0", seen); end
        csr_write(3'd1, 64'h0, 8'hFF);
        total++;
        if (bus.irq_req !== 1'b0) begin
            bad++;
            $display("FAIL unmask_latency0: got req=%b want 0", bus.irq_req);
        end
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vec !== 2'd0) begin
            bad++;
            $display("FAIL unmask_req: got req=%b vec=%0d want req=1 vec=0", bus.irq_req, bus.irq_vec);
        end
        do_ack();
        // CLEAR of line 0 coincident with a fresh rise on line 0.
        bus.avmm_address    = 3'd2;
        bus.avmm_writedata  = 64'h1;
        bus.avmm_byteenable = 8'hFF;
        bus.avmm_write      = 1'b1;
        irq_in              = 4'b0001;
        tick();
        bus.avmm_write      = 1'b0;
        total++;
        if (bus.irq_req !== 1'b0) begin
            bad++;
            $display("FAIL race_latency0: got req=%b want 0", bus.irq_req);
        end
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vec !== 2'd0) begin
            bad++;
            $display("FAIL race_req: got req=%b vec=%0d want req=1 vec=0", bus.irq_req, bus.irq_vec);
        end
        csr_read(3'd0, d);
        total++;
        if (d !== 64'h1) begin bad++; $display("FAIL race_pending: got %h want 1", d); end
        do_ack();
        irq_in = '0;
        csr_read(3'd4, d);
        total++;
        if (d !== 64'd2) begin bad++; $display("FAIL race_count: got %h want 2", d); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        bit ok;
        int seen;
        do_reset();
        csr_write(3'd1, 64'd0, 8'hFF);
        pulse(4'b0100);
        wait_req(6, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_setup: got req=0 want 1"); end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.irq_req !== 1'b0) begin
            bad++;
            $display("FAIL midreset_drop: got req=%b want 0", bus.irq_req);
        end
        #2;
        reset_n = 1'b1;
        tick();
        csr_read(3'd1, d);
        total++;
        if (d !== 64'hF) begin bad++; $display("FAIL midreset_mask: got %h want f", d); end
        csr_read(3'd0, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL midreset_pending: got %h want 0", d); end
        csr_read(3'd4, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL midreset_count: got %h want 0", d); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.irq_req === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL midreset_quiet: got %0d req cycles want 0", seen); end
    endtask

    task automatic test_spacing();
        bit ok;
        int gap;
        do_reset();
        csr_write(3'd1, 64'd0, 8'hFF);
        pulse(4'b0011);
        wait_req(6, ok);
        total++;
        if (!ok || bus.irq_vec !== 2'd0) begin
            bad++;
            $display("FAIL space_first: req=%b vec=%0d want req=1 vec=0", ok, bus.irq_vec);
        end
        do_ack();
        gap = 0;
        while (bus.irq_req !== 1'b1 && gap < 60) begin
            tick();
            gap++;
        end
        total++;
        if (bus.irq_vec !== 2'd1 || bus.irq_req !== 1'b1) begin
            bad++;
            $display("FAIL space_second: req=%b vec=%0d want req=1 vec=1", bus.irq_req, bus.irq_vec);
        end
`ifdef ASP_IRQ_HOLDOFF_EN
        total++;
        if (gap < int'(Holdoff) + 1) begin
            bad++;
            $display("FAIL space_holdoff: ack-to-req %0d cycles want >= %0d", gap, Holdoff + 1);
        end
`else
        total++;
        if (gap + 1 != 2) begin
            bad++;
            $display("FAIL space_b2b: req-to-req %0d cycles want 2", gap + 1);
        end
`endif
        do_ack();
    endtask

    task automatic test_csr();
        logic [63:0] d;
        do_reset();
        bus.avmm_address = 3'd1;
        bus.avmm_read    = 1'b1;
        tick();
        bus.avmm_read    = 1'b0;
        total++;
        if (bus.avmm_readdatavalid !== 1'b1 || bus.avmm_readdata !== 64'hF) begin
            bad++;
            $display("FAIL csr_rdv: rdv=%b data=%h want rdv=1 data=f",
                     bus.avmm_readdatavalid, bus.avmm_readdata);
        end
        tick();
        total++;
        if (bus.avmm_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL csr_rdv_drop: got %b want 0", bus.avmm_readdatavalid);
        end
        csr_write(3'd1, 64'h0, 8'h00);
        csr_read(3'd1, d);
        total++;
        if (d !== 64'hF) begin bad++; $display("FAIL csr_be_none: got %h want f", d); end
        csr_write(3'd1, 64'hFFFF_FFFF_FFFF_FF05, 8'h01);
        csr_read(3'd1, d);
        total++;
        if (d !== 64'h5) begin bad++; $display("FAIL csr_be_low: got %h want 5", d); end
        csr_write(3'd1, '1, 8'hFF);
        csr_read(3'd1, d);
        total++;
        if (d !== 64'hF) begin bad++; $display("FAIL csr_mask_width: got %h want f", d); end
        for (int a = 5; a < 8; a++) csr_write(3'(a), '1, 8'hFF);
        for (int a = 2; a < 8; a++) begin
            if (a == 3 || a == 4) continue;
            csr_read(3'(a), d);
            total++;
            if (d !== 64'h0) begin bad++; $display("FAIL csr_zero_addr%0d: got %h want 0", a, d); end
        end
        // Simultaneous read and write of MASK returns the old value.
        bus.avmm_address    = 3'd1;
        bus.avmm_writedata  = 64'h0;
        bus.avmm_byteenable = 8'hFF;
        bus.avmm_write      = 1'b1;
        bus.avmm_read       = 1'b1;
        tick();
        bus.avmm_write      = 1'b0;
        bus.avmm_read       = 1'b0;
        total++;
        if (bus.avmm_readdata !== 64'hF) begin
            bad++;
            $display("FAIL csr_rw_same: got %h want f", bus.avmm_readdata);
        end
        csr_read(3'd1, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL csr_rw_after: got %h want 0", d); end
        csr_write(3'd1, 64'hF, 8'hFF);
        irq_in = 4'b1010;
        tick();
        csr_read(3'd3, d);
        total++;
        if (d !== 64'hA) begin bad++; $display("FAIL csr_raw: got %h want a", d); end
        csr_read(3'd0, d);
        total++;
        if (d !== 64'h2) begin bad++; $display("FAIL csr_unused_line: got %h want 2", d); end
        irq_in = '0;
        tick();
    endtask

    // Model: a burst of rises becomes a set of pending lines; unmasked ones are
    // delivered lowest index first, masked ones wait until the mask is lifted.
    task automatic test_random();
        logic [63:0] d;
        logic [3:0]  p, m;
        int          exp_q[$];
        int          count_model;
        int          seen;
        bit          ok;
        do_reset();
        count_model = 0;
        for (int r = 0; r < 12; r++) begin
            csr_write(3'd2, 64'hF, 8'hFF);
            m = 4'($urandom_range(0, 15));
            p = 4'($urandom_range(1, 15));
            csr_write(3'd1, {60'd0, m}, 8'hFF);
            pulse(p);
            for (int phase = 0; phase < 2; phase++) begin
                exp_q.delete();
                for (int i = 0; i < int'(NumUsed); i++) begin
                    if (p[i] && (phase == 0 ? !m[i] : m[i])) exp_q.push_back(i);
                end
                foreach (exp_q[k]) begin
                    wait_req(8, ok);
                    total++;
                    if (!ok || bus.irq_vec !== 2'(exp_q[k])) begin
                        bad++;
                        $display("FAIL rand_msg r%0d ph%0d: req=%b vec=%0d want req=1 vec=%0d",
                                 r, phase, ok, bus.irq_vec, exp_q[k]);
                    end
                    bus.irq_ack = 1'b0;
                    for (int w = $urandom_range(0, 3); w > 0; w--) tick();
                    do_ack();
                    count_model++;
                end
                seen = 0;
                for (int i = 0; i < 8; i++) begin
                    if (bus.irq_req === 1'b1) seen++;
                    tick();
                end
                total++;
                if (seen != 0) begin
                    bad++;
                    $display("FAIL rand_extra r%0d ph%0d: got %0d req cycles want 0", r, phase, seen);
                end
                csr_read(3'd4, d);
                total++;
                if (d !== 64'(count_model)) begin
                    bad++;
                    $display("FAIL rand_count r%0d ph%0d: got %h want %h", r, phase, d, count_model);
                end
                if (phase == 0) begin
                    csr_read(3'd0, d);
                    total++;
                    if (d !== {61'd0, p[2:0]}) begin
                        bad++;
                        $display("FAIL rand_pending r%0d: got %h want %h", r, d, p[2:0]);
                    end
                    csr_write(3'd1, 64'd0, 8'hFF);
                end
            end
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single();
        test_two_lines();
        test_mask_then_clear_race();
        test_reset_mid();
        test_spacing();
        test_csr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
